// File: rtl/charlieplex_scan_driver.sv
// Charlieplexed LED matrix scanner.
// A serial loader fills a shadow frame; a commit copies it into the display
// frame on a frame boundary so a frame is never shown half-old, half-new.
// Each phase drives one source pin high and pulls the sink pins of lit LEDs
// low, with an optional all-tristate blanking window ahead of the active one.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  idle    | scan_q=0: run low or just out of reset, all pins tristated
//  scanning| scan_q=1: phase/tick advancing, outputs follow phase/tick
module charlieplex_scan_driver #(
  parameter int N_PINS = 5,
  parameter int DWELL  = 16,
  parameter int BLANK  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              load_en,
  input  logic              load_bit,
  input  logic              commit,
  output logic [N_PINS-1:0] pin_out,
  output logic [N_PINS-1:0] pin_oe,
  output logic              frame_start,
  output logic              commit_pending
);

  localparam int LEDS   = N_PINS * (N_PINS - 1);
  localparam int PERIOD = BLANK + DWELL;
  localparam int PW     = (N_PINS > 1) ? $clog2(N_PINS) : 1;
  localparam int TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [LEDS-1:0]   shadow_q;
  logic [LEDS-1:0]   display_q, display_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic              scan_q, scan_d;
  logic              pending_d;
  logic              frame_boundary;
  logic              apply_commit;
  logic              in_blank;
  logic [N_PINS-1:0] out_d, oe_d;

  // Shift register loader; the first bit shifted in ends up at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (load_en) begin
      shadow_q <= {load_bit, shadow_q[LEDS-1:1]};
    end
  end

  // Scan position, display frame, commit flag and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_q      <= '0;
      phase_q        <= '0;
      tick_q         <= '0;
      scan_q         <= 1'b0;
      commit_pending <= 1'b0;
      pin_out        <= '0;
      pin_oe         <= '0;
      frame_start    <= 1'b0;
    end else begin
      display_q      <= display_d;
      phase_q        <= phase_d;
      tick_q         <= tick_d;
      scan_q         <= scan_d;
      commit_pending <= pending_d;
      pin_out        <= out_d;
      pin_oe         <= oe_d;
      frame_start    <= frame_boundary;
    end
  end

  // Next scan position; restarting from idle counts as a frame boundary.
  always_comb begin
    phase_d        = '0;
    tick_d         = '0;
    scan_d         = 1'b0;
    frame_boundary = 1'b0;
    if (run) begin
      scan_d = 1'b1;
      if (!scan_q) begin
        frame_boundary = 1'b1;
      end else if (tick_q == TW'(PERIOD - 1)) begin
        if (phase_q == PW'(N_PINS - 1)) begin
          frame_boundary = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end else begin
        tick_d  = tick_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  // Commit lands on the frame boundary, or immediately when not scanning.
  // The copy takes the shadow as registered, ignoring a same-cycle shift.
  always_comb begin
    apply_commit = commit_pending && (!run || frame_boundary);
    display_d    = apply_commit ? shadow_q : display_q;
    pending_d    = apply_commit ? 1'b0 : (commit_pending | commit);
  end

  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (tick_d < TW'(BLANK));
    end
  endgenerate

  // Pin pattern for the phase being entered, using the frame it will show.
  always_comb begin
    out_d = '0;
    oe_d  = '0;
    if (run && !in_blank) begin
      for (int p = 0; p < N_PINS; p++) begin
        if (phase_d == PW'(p)) begin
          out_d[p] = 1'b1;
          oe_d[p]  = 1'b1;
          for (int q = 0; q < N_PINS; q++) begin
            if (q != p) begin
              oe_d[q] = display_d[p * (N_PINS - 1) + ((q < p) ? q : q - 1)];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_charlieplex_scan_driver.sv
// Scoreboard bench: a frame-level reference model predicts the pins of two
// differently sized scanners each clock; a monitor compares on the far edge.
module tb_charlieplex_scan_driver;

  localparam int A_N = 5, A_B = 1, A_D = 4;
  localparam int B_N = 2, B_B = 0, B_D = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic a_run = 0, a_le = 0, a_lb = 0, a_cm = 0;
  logic [A_N-1:0] a_out, a_oe;
  logic a_fs, a_pend;

  logic b_run = 0, b_le = 0, b_lb = 0, b_cm = 0;
  logic [B_N-1:0] b_out, b_oe;
  logic b_fs, b_pend;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] oe;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int passes = 0;

  int m_n[2], m_b[2], m_d[2], m_cyc[2];
  bit m_sh[2][56];
  bit m_disp[2][56];
  bit m_pend[2], m_act[2];

  charlieplex_scan_driver #(.N_PINS(A_N), .DWELL(A_D), .BLANK(A_B)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(a_run), .load_en(a_le), .load_bit(a_lb),
    .commit(a_cm), .pin_out(a_out), .pin_oe(a_oe), .frame_start(a_fs),
    .commit_pending(a_pend)
  );

  charlieplex_scan_driver #(.N_PINS(B_N), .DWELL(B_D), .BLANK(B_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(b_run), .load_en(b_le), .load_bit(b_lb),
    .commit(b_cm), .pin_out(b_out), .pin_oe(b_oe), .frame_start(b_fs),
    .commit_pending(b_pend)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Reference: position derived from cycles elapsed since the scan started.
  task automatic model_step(input int k, input bit rn, input bit le, input bit lb,
                            input bit cm, output exp_t e);
    int l, per, f, ph, tk;
    bit old[56];
    bit bnd;
    e = '0;
    if (!rst_n) begin
      for (int i = 0; i < 56; i++) begin
        m_sh[k][i] = 0;
        m_disp[k][i] = 0;
      end
      m_pend[k] = 0;
      m_act[k] = 0;
      m_cyc[k] = 0;
      return;
    end
    l   = m_n[k] * (m_n[k] - 1);
    per = m_b[k] + m_d[k];
    f   = m_n[k] * per;
    for (int i = 0; i < 56; i++) old[i] = m_sh[k][i];
    bnd = 0;
    if (rn) begin
      if (!m_act[k]) m_cyc[k] = 0;
      else m_cyc[k]++;
      bnd = (m_cyc[k] % f == 0);
    end
    if (m_pend[k] && (!rn || bnd)) begin
      for (int i = 0; i < l; i++) m_disp[k][i] = old[i];
      m_pend[k] = 0;
    end else if (cm) begin
      m_pend[k] = 1;
    end
    if (le) begin
      for (int i = 0; i < l - 1; i++) m_sh[k][i] = old[i + 1];
      m_sh[k][l - 1] = lb;
    end
    m_act[k] = rn;
    e.pend = m_pend[k];
    if (rn) begin
      ph = (m_cyc[k] % f) / per;
      tk = m_cyc[k] % per;
      e.fs = bnd;
      if (tk >= m_b[k]) begin
        e.out[ph] = 1'b1;
        e.oe[ph]  = 1'b1;
        for (int q = 0; q < m_n[k]; q++)
          if (q != ph) e.oe[q] = m_disp[k][ph * (m_n[k] - 1) + ((q < ph) ? q : q - 1)];
      end
    end
  endtask

  // Predict each edge's outcome from the inputs it samples.
  always @(posedge clk) begin
    exp_t e;
    model_step(0, a_run, a_le, a_lb, a_cm, e);
    q_a.push_back(e);
    model_step(1, b_run, b_le, b_lb, b_cm, e);
    q_b.push_back(e);
  end

  // Compare registered outputs mid-cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() == 0) begin
      checks++;
      $display("FAIL a_queue: no prediction, got empty expected 1 entry");
    end else begin
      e = q_a.pop_front();
      check("a_pin_out", {3'b0, a_out}, e.out);
      check("a_pin_oe", {3'b0, a_oe}, e.oe);
      check("a_frame_start", {7'b0, a_fs}, {7'b0, e.fs});
      check("a_commit_pending", {7'b0, a_pend}, {7'b0, e.pend});
    end
    if (q_b.size() == 0) begin
      checks++;
      $display("FAIL b_queue: no prediction, got empty expected 1 entry");
    end else begin
      e = q_b.pop_front();
      check("b_pin_out", {6'b0, b_out}, e.out);
      check("b_pin_oe", {6'b0, b_oe}, e.oe);
      check("b_frame_start", {7'b0, b_fs}, {7'b0, e.fs});
      check("b_commit_pending", {7'b0, b_pend}, {7'b0, e.pend});
    end
  end

  // Small instance: free-running random stimulus.
  initial begin
    forever begin
      @(negedge clk);
      b_run = ($urandom_range(0, 19) != 0);
      b_le  = $urandom_range(0, 1) == 1;
      b_lb  = $urandom_range(0, 1) == 1;
      b_cm  = ($urandom_range(0, 9) == 0);
    end
  end

  initial begin
    m_n[0] = A_N; m_b[0] = A_B; m_d[0] = A_D;
    m_n[1] = B_N; m_b[1] = B_B; m_d[1] = B_D;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single lit LED at index 0, committed while idle
    for (int i = 0; i < 20; i++) begin
      a_le = 1'b1;
      a_lb = (i == 0);
      @(negedge clk);
    end
    a_le = 1'b0;
    a_cm = 1'b1;
    @(negedge clk);
    a_cm = 1'b0;
    repeat (2) @(negedge clk);
    a_run = 1'b1;
    repeat (50) @(negedge clk);

    // load full pattern while scanning, commit mid-frame
    for (int i = 0; i < 20; i++) begin
      a_le = 1'b1;
      a_lb = 1'b1;
      @(negedge clk);
    end
    a_le = 1'b0;
    repeat (7) @(negedge clk);
    a_cm = 1'b1;
    @(negedge clk);
    a_cm = 1'b0;
    repeat (60) @(negedge clk);

    // run dropped mid-frame then restored
    repeat (13) @(negedge clk);
    a_run = 1'b0;
    repeat (3) @(negedge clk);
    a_run = 1'b1;
    repeat (30) @(negedge clk);

    // random traffic
    repeat (3000) begin
      a_run = ($urandom_range(0, 39) != 0);
      a_le  = ($urandom_range(0, 3) == 0);
      a_lb  = $urandom_range(0, 1) == 1;
      a_cm  = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end

    // asynchronous reset mid-frame with a commit outstanding
    a_run = 1'b1;
    a_le  = 1'b0;
    a_cm  = 1'b0;
    repeat (30) @(negedge clk);
    a_cm = 1'b1;
    @(negedge clk);
    a_cm = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_pin_oe", {3'b0, a_oe}, 8'h00);
    check("async_rst_pin_out", {3'b0, a_out}, 8'h00);
    check("async_rst_pending", {7'b0, a_pend}, 8'h00);
    check("async_rst_b_pin_oe", {6'b0, b_oe}, 8'h00);
    check("async_rst_b_pin_out", {6'b0, b_out}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/charlieplex_scan_driver.md
# charlieplex_scan_driver

Parametrised charlieplexed LED matrix scanner for an N-pin bidirectional port, driving N·(N−1) LEDs from a double-buffered frame held in registers. A serial loader fills a shadow buffer; a commit transfers it to the display buffer on a frame boundary, so frames never tear. Adds programmable dwell, inter-phase blanking against ghosting, and a run gate. The block sits between the user-input pins (serial load/control) and the uio output/enable pins.

## Interface

- N_PINS, 5, number of charlieplex pins; legal 2..8; LEDS = N_PINS·(N_PINS−1)
- DWELL, 16, active cycles per phase; legal ≥1
- BLANK, 1, all-tristate cycles before each phase's active window; legal ≥0

- clk  in  1  single clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  1 = scan; 0 = all pins tristated, scan held at phase 0
- load_en  in  1  shift load_bit into shadow buffer this cycle
- load_bit  in  1  serial frame data
- commit  in  1  single-cycle request: shadow → display
- pin_out  out  N_PINS  driven levels (uio_out)
- pin_oe  out  N_PINS  output enables, 1 = drive (uio_oe)
- frame_start  out  1  one-cycle pulse on first cycle of each frame
- commit_pending  out  1  commit accepted, not yet applied

## Operation

- Shadow buffer, LEDS bits: on load_en, shadow <= {load_bit, shadow[LEDS−1:1]}; after LEDS shifts the first bit written sits at bit 0.
- LED index for source (high) pin p, sink pin q≠p: idx = p·(N_PINS−1) + (q<p ? q : q−1).
- State: phase 0..N_PINS−1, tick 0..BLANK+DWELL−1. tick increments each cycle while run=1; at terminal tick wraps to 0 and phase advances; phase N_PINS−1 wraps to 0 (frame boundary).
- Blank window (tick < BLANK): pin_oe=0, pin_out=0.
- Active window: pin_out = one-hot(p); pin_oe[p]=1; pin_oe[q]=display[idx(p,q)] for q≠p (driven low). Unlit LED = sink left tristated.
- commit: sets commit_pending. If run=1, display <= shadow at the edge that starts phase 0/tick 0 of the next frame; pending cleared at that edge. If run=0, copy happens on the next edge (pending high one cycle).
- Copy uses shadow value registered before any load_en shift in the same cycle. commit while pending already set: no extra effect.
- run=0: phase/tick forced to 0 next edge; pin_oe/pin_out/frame_start 0. Shadow loading and commit continue to work.
- Reset: shadow, display, phase, tick, commit_pending, pin_out, pin_oe, frame_start all 0.

## Timing

- pin_out, pin_oe, frame_start registered; they reflect the phase/tick value entered at the same edge (no extra latency beyond one register).
- Edge E0 = first rising edge with run=1 after run=0: cycle after E0 is phase 0, tick 0; frame_start=1 that cycle only.
- Phase p active window: cycles E0+p·(BLANK+DWELL)+BLANK+1 … +DWELL. Frame period F = N_PINS·(BLANK+DWELL) cycles; frame_start repeats every F.
- BLANK=0: phases abut, no tristate gap; frame_start coincides with first active cycle of phase 0.
- run falling mid-frame: cycle after the sampling edge all outputs 0; pending commit applied on that edge.
- rst_n low: outputs 0 immediately (asynchronous), independent of clk.

## Test plan

- Reset: assert rst_n=0 mid-frame with N_PINS=5 -> pin_oe=0, pin_out=0, commit_pending=0 without a clock edge; display reads back all-dark.
- Load/commit idle: N_PINS=5, run=0, shift 20 bits with only first bit=1, commit, run=1, BLANK=1, DWELL=4 -> phase 0 active cycles: pin_out=00001, pin_oe=00011 (sink pin 1 from idx 0); other phases pin_oe=one-hot only.
- Deferred commit: run=1, commit at tick 2 of phase 2 -> commit_pending high until frame boundary; phases 2–4 show old frame, new frame from next frame_start.
- Full pattern: all 20 bits=1 -> every active cycle pin_oe=11111, pin_out=one-hot rotating 00001→00010→…→10000, period 25 cycles.
- run drop: run=0 during phase 3 -> next cycle outputs 0; run=1 again -> frame_start pulse, restarts at phase 0.
- Parameter sweep: N_PINS=2, BLANK=0, DWELL=1 -> frame period 2, pin_out alternates 01/10, frame_start every 2 cycles.
